// File: rtl/pipe_skid_stage_pkg.sv
// Shared pipeline-stage types: occupancy encoding for the elastic stage FSM.
package pipe_skid_stage_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL1 = 2'd1,
    FULL2 = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Upstream/downstream valid-ready handshake bundle for one pipeline boundary.
// The slave modport is the stage's view; master is the surrounding logic's view.
interface pipe_skid_stage_if #(
  parameter int DATA_W = 64
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

endinterface

// File: rtl/pipe_skid_stage.sv
// Elastic two-entry skid pipeline register with a fully registered in_ready.
// Main register drives the output; the skid register absorbs one beat of backpressure.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  pipe_skid_stage_if.slave        bus
);

  occ_e              state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              accept;
  logic              emit;

  assign accept = bus.in_valid && in_ready_q;
  assign emit   = out_valid_q && bus.out_ready;

  // in_data is only copied on accept, so X on an idle bus never reaches main_q
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = RESET_DATA;
      skid_d  = RESET_DATA;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = bus.in_data;
            state_d = FULL1;
          end
        end
        FULL1: begin
          if (accept && emit) begin
            main_d = bus.in_data;
          end else if (accept) begin
            skid_d  = bus.in_data;
            state_d = FULL2;
          end else if (emit) begin
            state_d = EMPTY;
          end
        end
        FULL2: begin
          if (emit) begin
            main_d  = skid_q;
            state_d = FULL1;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
    // Handshake outputs come straight from flops, decoded from the next state
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL2);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      main_q      <= RESET_DATA;
      skid_q      <= RESET_DATA;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed vector table plus reset/flush corner sequences and a random scoreboard run
// for the elastic skid pipeline stage.
module tb_pipe_skid_stage;

  localparam int DATA_W = 64;

  typedef struct {
    logic              in_valid;
    logic              out_ready;
    logic              flush;
    logic [DATA_W-1:0] in_data;
    logic              exp_out_valid;
    logic              exp_in_ready;
    logic [DATA_W-1:0] exp_out_data;
  } vec_t;

  logic clock;
  logic reset;
  logic flush;
  int   tests_run;
  int   tests_failed;
  vec_t vecs[$];

  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] last_head;
  int                in_cnt;
  int                out_cnt;

  pipe_skid_stage_if #(.DATA_W(DATA_W)) bus ();

  pipe_skid_stage #(
    .DATA_W    (DATA_W),
    .RESET_DATA('0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic iv, input logic ord, input logic fl,
                              input logic [DATA_W-1:0] din, input logic eov,
                              input logic eir, input logic [DATA_W-1:0] eod);
    vec_t v;
    v.in_valid      = iv;
    v.out_ready     = ord;
    v.flush         = fl;
    v.in_data       = din;
    v.exp_out_valid = eov;
    v.exp_in_ready  = eir;
    v.exp_out_data  = eod;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [DATA_W-1:0] act,
                              input logic [DATA_W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input logic eov, input logic eir,
                             input logic [DATA_W-1:0] eod);
    check_output({name, ".out_valid"}, {63'd0, bus.out_valid}, {63'd0, eov});
    check_output({name, ".in_ready"}, {63'd0, bus.in_ready}, {63'd0, eir});
    check_output({name, ".out_data"}, bus.out_data, eod);
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge
  task automatic apply_stimulus(input logic iv, input logic ord, input logic fl,
                                input logic [DATA_W-1:0] din);
    bus.in_valid  = iv;
    bus.out_ready = ord;
    flush         = fl;
    bus.in_data   = din;
    @(posedge clock);
    #1;
  endtask

  // Reference queue: occupancy = size, head = out_data while non-empty
  task automatic random_cycle(input logic iv, input logic ord, input logic [DATA_W-1:0] din);
    logic m_emit;
    logic m_accept;
    m_emit   = (model_q.size() > 0) && ord;
    m_accept = iv && (model_q.size() < 2);
    if (iv && bus.in_ready) in_cnt++;
    if (bus.out_valid && ord) out_cnt++;
    apply_stimulus(iv, ord, 1'b0, din);
    if (m_emit) void'(model_q.pop_front());
    if (m_accept) model_q.push_back(din);
    if (model_q.size() > 0) last_head = model_q[0];
    check_state("random", model_q.size() > 0, model_q.size() < 2, last_head);
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    bus.in_data   = 64'h55;

    // Reset held for three edges with valid input offered
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check_state("reset_hold", 1'b0, 1'b1, 64'h0);
    end
    reset = 1'b1;
    apply_stimulus(1'b1, 1'b1, 1'b0, 64'h77);
    check_state("first_accept", 1'b1, 1'b1, 64'h77);
    apply_stimulus(1'b0, 1'b1, 1'b0, 64'h0);
    check_state("first_drain", 1'b0, 1'b1, 64'h77);

    // Streaming 0x1..0x8 at full rate
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(1, 1, 0, DATA_W'(i), 1, 1, DATA_W'(i)));
    vecs.push_back(mk(0, 1, 0, 64'h0, 0, 1, 64'h8));
    // Backpressure: A to main, B to skid, C held upstream
    vecs.push_back(mk(1, 0, 0, 64'hA, 1, 1, 64'hA));
    vecs.push_back(mk(1, 0, 0, 64'hB, 1, 0, 64'hA));
    vecs.push_back(mk(1, 0, 0, 64'hC, 1, 0, 64'hA));
    vecs.push_back(mk(1, 1, 0, 64'hC, 1, 1, 64'hB));
    vecs.push_back(mk(1, 1, 0, 64'hC, 1, 1, 64'hC));
    vecs.push_back(mk(0, 1, 0, 64'h0, 0, 1, 64'hC));
    // Hold in FULL1 with no activity
    vecs.push_back(mk(1, 0, 0, 64'h20, 1, 1, 64'h20));
    vecs.push_back(mk(0, 0, 0, 64'h0, 1, 1, 64'h20));
    vecs.push_back(mk(0, 1, 0, 64'h0, 0, 1, 64'h20));
    // Flush in FULL2 while 0xD is offered
    vecs.push_back(mk(1, 0, 0, 64'h21, 1, 1, 64'h21));
    vecs.push_back(mk(1, 0, 0, 64'h22, 1, 0, 64'h21));
    vecs.push_back(mk(1, 0, 1, 64'hD, 0, 1, 64'h0));
    vecs.push_back(mk(0, 1, 0, 64'h0, 0, 1, 64'h0));
    // Flush from EMPTY with in_ready=1 still discards the offered beat
    vecs.push_back(mk(1, 1, 1, 64'hE, 0, 1, 64'h0));
    vecs.push_back(mk(0, 1, 0, 64'h0, 0, 1, 64'h0));
    // Flush in FULL1 alongside an emit
    vecs.push_back(mk(1, 0, 0, 64'h40, 1, 1, 64'h40));
    vecs.push_back(mk(1, 1, 1, 64'h41, 0, 1, 64'h0));
    vecs.push_back(mk(0, 1, 0, 64'h0, 0, 1, 64'h0));

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].in_valid, vecs[i].out_ready, vecs[i].flush, vecs[i].in_data);
      check_state($sformatf("vec%0d", i), vecs[i].exp_out_valid, vecs[i].exp_in_ready,
                  vecs[i].exp_out_data);
    end

    // Async reset asserted mid-cycle while FULL2
    apply_stimulus(1'b1, 1'b0, 1'b0, 64'h30);
    apply_stimulus(1'b1, 1'b0, 1'b0, 64'h31);
    check_state("pre_async_full2", 1'b1, 1'b0, 64'h30);
    #3;
    reset = 1'b0;
    #1;
    check_state("async_reset", 1'b0, 1'b1, 64'h0);
    bus.in_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    apply_stimulus(1'b1, 1'b1, 1'b0, 64'h10);
    check_state("post_reset_10", 1'b1, 1'b1, 64'h10);
    apply_stimulus(1'b1, 1'b1, 1'b0, 64'h11);
    check_state("post_reset_11", 1'b1, 1'b1, 64'h11);
    apply_stimulus(1'b0, 1'b1, 1'b0, 64'h0);
    check_state("post_reset_idle", 1'b0, 1'b1, 64'h11);
    apply_stimulus(1'b0, 1'b1, 1'b0, 64'h0);
    check_state("no_stale", 1'b0, 1'b1, 64'h11);

    // Random valid/ready against the reference queue
    model_q.delete();
    last_head = 64'h11;
    in_cnt    = 0;
    out_cnt   = 0;
    for (int c = 0; c < 10000; c++)
      random_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   {$urandom, $urandom});
    for (int c = 0; c < 3; c++)
      random_cycle(1'b0, 1'b1, 64'h0);
    check_output("count_in_vs_out", 64'(out_cnt), 64'(in_cnt));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
